// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES types, FSM state encoding and GF(2^8) helpers for the
// iterative MixColumns block.
//   aes_byte_t  : one state byte
//   aes_col_t   : one 32-bit column, row 0 in bits [31:24]
//   aes_state_t : full 128-bit state, column 0 in bits [127:96]
//   xtime/gmul  : multiplication in GF(2^8) modulo x^8+x^4+x^3+x+1
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef logic [7:0]   aes_byte_t;
    typedef logic [31:0]  aes_col_t;
    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_t;

    // Low byte of the field polynomial 0x11B; the x^8 term is the shifted-out MSB.
    localparam aes_byte_t AES_REDUCE = 8'h1B;

    function automatic aes_byte_t xtime(input aes_byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_REDUCE : 8'h00);
    endfunction

    // Multiply by a 4-bit constant: XOR of the x1/x2/x4/x8 xtime chain,
    // which covers every MixColumns coefficient (1,2,3,9,b,d,e).
    function automatic aes_byte_t gmul(input aes_byte_t a, input logic [3:0] k);
        aes_byte_t x2;
        aes_byte_t x4;
        aes_byte_t x8;
        aes_byte_t r;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        r  = 8'h00;
        if (k[0]) r = r ^ a;
        if (k[1]) r = r ^ x2;
        if (k[2]) r = r ^ x4;
        if (k[3]) r = r ^ x8;
        return r;
    endfunction

endpackage

// File: rtl/mix_column_one.sv
// ---------------------------------------------------------------------------
// mix_column_one
// Purely combinational MixColumns on a single 32-bit column.
//   INVERSE : 0 = forward matrix rows rotated from (2,3,1,1),
//             1 = inverse matrix rows rotated from (e,b,d,9)
//   col_in  : input column, row 0 in bits [31:24]
//   col_out : transformed column, same layout
// ---------------------------------------------------------------------------
module mix_column_one
    import aes_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    // Coefficient applied to byte j of the column in output row r is
    // coef((j - r) mod 4): each row is the previous one rotated right.
    function automatic logic [3:0] coef(input int idx);
        logic [3:0] c;
        case (idx)
            0:       c = INVERSE ? 4'he : 4'h2;
            1:       c = INVERSE ? 4'hb : 4'h3;
            2:       c = INVERSE ? 4'hd : 4'h1;
            default: c = INVERSE ? 4'h9 : 4'h1;
        endcase
        return c;
    endfunction

    aes_byte_t a [4];
    aes_byte_t b [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row
            assign a[gi] = col_in[31 - 8*gi -: 8];
            assign b[gi] = gmul(a[0], coef((0 - gi + 4) % 4))
                         ^ gmul(a[1], coef((1 - gi + 4) % 4))
                         ^ gmul(a[2], coef((2 - gi + 4) % 4))
                         ^ gmul(a[3], coef((3 - gi + 4) % 4));
            assign col_out[31 - 8*gi -: 8] = b[gi];
        end
    endgenerate

endmodule

// File: rtl/mix_columns_iter.sv
// ---------------------------------------------------------------------------
// mix_columns_iter
// Iterative AES MixColumns: captures a 128-bit state, transforms one column
// per cycle through a single mix_column_one instance, then presents the
// result until the consumer takes it.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : input handshake (ready only in IDLE)
//   in_state              : 128-bit state, column c at [127-32c : 96-32c]
//   out_valid / out_ready : output handshake (valid only in DONE)
//   out_state             : transformed state, meaningful only in DONE
// ---------------------------------------------------------------------------
module mix_columns_iter
    import aes_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    fsm_state_t state_q, state_d;
    logic [1:0] col_q,   col_d;
    aes_state_t work_q,  work_d;

    aes_col_t col_sel;
    aes_col_t col_mixed;

    // Pick the column addressed by the counter.
    always_comb begin
        col_sel = work_q[127:96];
        for (int c = 0; c < 4; c++) begin
            if (col_q == 2'(c)) begin
                col_sel = work_q[127 - 32*c -: 32];
            end
        end
    end

    mix_column_one #(
        .INVERSE (INVERSE)
    ) u_mix_column_one (
        .col_in  (col_sel),
        .col_out (col_mixed)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        work_d  = work_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d  = in_state;
                    col_d   = 2'd0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Result overwrites its own column; other columns untouched.
                for (int c = 0; c < 4; c++) begin
                    if (col_q == 2'(c)) begin
                        work_d[127 - 32*c -: 32] = col_mixed;
                    end
                end
                // Counter wraps 3->0 on the same edge that enters DONE.
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                col_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            col_q   <= 2'd0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            work_q  <= work_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_state = work_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// ---------------------------------------------------------------------------
// tb_mix_columns_iter
// Drives a forward and an inverse instance with identical stimulus and checks
// both against a matrix-multiply reference model of MixColumns.
// ---------------------------------------------------------------------------
module tb_mix_columns_iter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [127:0] in_state = '0;
    logic         out_ready = 1'b0;

    logic         f_in_ready, f_out_valid;
    logic [127:0] f_out_state;
    logic         i_in_ready, i_out_valid;
    logic [127:0] i_out_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mix_columns_iter #(.INVERSE(1'b0)) dut_fwd (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (f_in_ready),
        .in_state  (in_state),
        .out_valid (f_out_valid),
        .out_ready (out_ready),
        .out_state (f_out_state)
    );

    mix_columns_iter #(.INVERSE(1'b1)) dut_inv (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (i_in_ready),
        .in_state  (in_state),
        .out_valid (i_out_valid),
        .out_ready (out_ready),
        .out_state (i_out_state)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: GF(2^8) multiply by shift-and-add with full 0x11B reduction.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] aa;
        logic [7:0] p;
        aa = {1'b0, a};
        p  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa[7:0];
            aa = aa << 1;
            if (aa[8]) aa = aa ^ 9'h11B;
        end
        return p;
    endfunction

    // Reference: full-state matrix product, circulant matrix from first row.
    function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv);
        logic [7:0]   row0 [4];
        logic [7:0]   a [4];
        logic [7:0]   acc;
        logic [127:0] r;
        if (inv) begin
            row0[0] = 8'h0e; row0[1] = 8'h0b; row0[2] = 8'h0d; row0[3] = 8'h09;
        end else begin
            row0[0] = 8'h02; row0[1] = 8'h03; row0[2] = 8'h01; row0[3] = 8'h01;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
            for (int rr = 0; rr < 4; rr++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gf_mul(a[j], row0[(j - rr + 4) % 4]);
                r[127 - 32*c - 8*rr -: 8] = acc;
            end
        end
        return r;
    endfunction

    // Offer a state, wait for acceptance and for out_valid. Leaves both DUTs in DONE.
    task automatic send_and_wait(input logic [127:0] s, input string tag);
        int waited;
        int edges;
        waited = 0;
        while (!f_in_ready && waited < 20) begin
            @(posedge clk); #1; waited++;
        end
        check({tag, "_in_ready_wait"}, 128'(f_in_ready), 128'(1));
        in_state = s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 1;
        while (!f_out_valid && edges < 20) begin
            @(posedge clk); #1; edges++;
        end
        check({tag, "_latency"}, 128'(edges), 128'(5));
        check({tag, "_inv_valid"}, 128'(i_out_valid), 128'(1));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_idle_ready"}, 128'({f_in_ready, i_in_ready, f_out_valid, i_out_valid}), 128'(4'b1100));
    endtask

    logic [127:0] st;
    logic [127:0] held_f;
    logic [127:0] held_i;
    logic [127:0] kat;
    logic [31:0]  c32;

    initial begin
        // Reset state
        #1;
        check("rst_fwd", {f_in_ready, f_out_valid, f_out_state}, {1'b1, 1'b0, 128'h0});
        check("rst_inv", {i_in_ready, i_out_valid, i_out_state}, {1'b1, 1'b0, 128'h0});
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Forward known answer, inverse against model
        kat = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        send_and_wait(kat, "kat_fwd");
        check("kat_fwd_out", f_out_state, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
        check("kat_fwd_inv_model", i_out_state, ref_mix(kat, 1'b1));
        release_out("kat_fwd");

        // Uniform columns
        c32 = 32'hd4d4d4d5;
        send_and_wait({4{c32}}, "col_d4");
        check("col_d4_out", f_out_state, {4{32'hd5d5d7d6}});
        release_out("col_d4");
        c32 = 32'h2d26314c;
        send_and_wait({4{c32}}, "col_2d");
        check("col_2d_out", f_out_state, {4{32'h4d7ebdf8}});
        release_out("col_2d");

        // Inverse known answer
        kat = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
        send_and_wait(kat, "kat_inv");
        check("kat_inv_out", i_out_state, 128'hdb135345_f20a225c_01010101_c6c6c6c6);
        check("kat_inv_fwd_model", f_out_state, ref_mix(kat, 1'b0));

        // Stall in DONE for 10 cycles, then pulse a new input that must be ignored
        held_f = f_out_state;
        held_i = i_out_state;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("stall_hold", {f_out_state, i_out_state[0]}, {held_f, held_i[0]});
            check("stall_flags", 128'({f_in_ready, i_in_ready, f_out_valid, i_out_valid}), 128'(4'b0011));
        end
        in_state = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("ignore_fwd", f_out_state, held_f);
        check("ignore_inv", i_out_state, held_i);
        release_out("stall");

        // Reset during BUSY at col=2
        st = {$urandom, $urandom, $urandom, $urandom};
        in_state = st;
        in_valid = 1'b1;
        @(posedge clk); #1;          // accepted, col=0
        in_valid = 1'b0;
        @(posedge clk); #1;          // col=1
        @(posedge clk); #1;          // col=2
        rst = 1'b1;
        #1;
        check("midrst_flags", 128'({f_in_ready, i_in_ready, f_out_valid, i_out_valid}), 128'(4'b1100));
        check("midrst_work", f_out_state, 128'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        st = {$urandom, $urandom, $urandom, $urandom};
        send_and_wait(st, "post_rst");
        check("post_rst_fwd", f_out_state, ref_mix(st, 1'b0));
        check("post_rst_inv", i_out_state, ref_mix(st, 1'b1));
        release_out("post_rst");

        // Randomized states against the model, with random output back-pressure
        for (int n = 0; n < 20; n++) begin
            st = {$urandom, $urandom, $urandom, $urandom};
            send_and_wait(st, "rand");
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            check("rand_fwd", f_out_state, ref_mix(st, 1'b0));
            check("rand_inv", i_out_state, ref_mix(st, 1'b1));
            release_out("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mix_columns_iter.md
MIX_COLUMNS_ITER -- requirements
Module: mix_columns_iter

Interface
REQ-001 The block SHALL have parameter INVERSE, default 0: 0 selects forward MixColumns (2,3,1,1); 1 selects inverse (e,b,d,9).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-004 The block SHALL have port in_valid, input, 1, input state offered.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept a state.
REQ-006 The block SHALL have port in_state, input, 128, AES state: column c = bits [127-32c : 96-32c], row 0 in the top byte of each column.
REQ-007 The block SHALL have port out_valid, output, 1, result available.
REQ-008 The block SHALL have port out_ready, input, 1, consumer accepts result.
REQ-009 The block SHALL have port out_state, output, 128, transformed state, same layout as in_state.

Function
REQ-010 The block SHALL implement FSM states IDLE, BUSY and DONE.
REQ-011 IDLE SHALL drive in_ready=1; in_valid=1 SHALL capture in_state into a 128-bit working register, clear col counter to 0, and go to BUSY.
REQ-012 BUSY SHALL transform exactly one column per cycle in order 0,1,2,3, writing the result in place; after column 3 the FSM SHALL go to DONE.
REQ-013 Forward mode SHALL compute, per column (a0..a3): b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3, in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11B).
REQ-014 Inverse mode SHALL compute b0=e·a0^b·a1^d·a2^9·a3, rotating the coefficients per row exactly as in forward mode.
REQ-015 The xtime operation SHALL be an 8-bit left shift, XORed with 0x1B when the input MSB is 1; all other multiplies SHALL be XORs of xtime chains.
REQ-016 DONE SHALL drive out_valid=1 and out_state=working register; out_state SHALL hold stable while out_valid=1 and out_ready=0.
REQ-017 In DONE, out_ready=1 SHALL complete the transfer and return the FSM to IDLE the next cycle.
REQ-018 in_ready SHALL be 0 in BUSY and DONE; in_valid in those states SHALL be ignored and the input SHALL NOT be captured.
REQ-019 Latency SHALL be exactly 5 cycles from the accepting edge to the first cycle out_valid=1: 1 capture edge plus 4 column edges.
REQ-020 Throughput SHALL be at most one state per 6 cycles; back-to-back operation SHALL NOT be required.
REQ-021 The col counter SHALL be 2 bits, advance only in BUSY, and its wrap 3->0 SHALL coincide with the BUSY->DONE transition.
REQ-022 out_state SHALL be undefined outside DONE.

Reset
REQ-023 rst=1 SHALL, asynchronously, set the FSM to IDLE, col to 0, the working register to 0, out_valid=0 and in_ready=1.
REQ-024 Reset asserted mid-BUSY or mid-DONE SHALL discard the in-flight state without emitting it.
REQ-025 The first capture SHALL occur on the first rising edge after rst deasserts with in_valid=1.

Structure
REQ-026 Package aes_pkg SHALL hold the state typedefs (byte, 32-bit column, 128-bit state), the FSM state enum, the reduction constant 0x1B, and the xtime/gmul functions.
REQ-027 One combinational sub-module, mix_column_one, SHALL map a 32-bit column to a 32-bit column under the INVERSE parameter; mix_columns_iter SHALL instantiate it once and mux the column selected by col.

Verification
REQ-028 The bench SHALL apply forward, in_state=db135345_f20a225c_01010101_c6c6c6c6 -> out_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid exactly 5 cycles after acceptance.
REQ-029 The bench SHALL apply forward, column d4d4d4d5 in every column -> d5d5d7d6 in every column; column 2d26314c -> 4d7ebdf8.
REQ-030 The bench SHALL apply INVERSE=1, in_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> db135345_f20a225c_01010101_c6c6c6c6.
REQ-031 The bench SHALL hold out_ready=0 for 10 cycles in DONE -> out_state stable, in_ready=0; then pulse in_valid with a new state -> ignored; on out_ready=1, back in IDLE the next cycle.
REQ-032 The bench SHALL assert rst during BUSY at col=2 -> out_valid=0 and in_ready=1 immediately; the next state is processed correctly with no residue from the discarded one.
